// File: rtl/ex_mdu_ctl_if.sv
// Handshake/operand bundle between the EX stage and the RV32M multiply/divide unit.
// master = pipeline side, slave = MDU side.
interface ex_mdu_ctl_if #(
   parameter int XLEN = 32
);
   logic            mdu_start_i;
   logic [2:0]      mdu_op_i;
   logic [XLEN-1:0] rs1_rd_data_i;
   logic [XLEN-1:0] rs2_rd_data_i;
   logic            mdu_flush_i;
   logic            mdu_busy_o;
   logic            mdu_done_o;
   logic [XLEN-1:0] mdu_data_o;

   modport master (
      output mdu_start_i, mdu_op_i, rs1_rd_data_i, rs2_rd_data_i, mdu_flush_i,
      input  mdu_busy_o, mdu_done_o, mdu_data_o
   );

   modport slave (
      input  mdu_start_i, mdu_op_i, rs1_rd_data_i, rs2_rd_data_i, mdu_flush_i,
      output mdu_busy_o, mdu_done_o, mdu_data_o
   );
endinterface

// File: rtl/ex_mdu_ctl.sv
// RV32M multiply/divide sequencer: iterative shift-add multiply, restoring divide.
// Define MDU_FAST_MUL_EN to route multiplies through a single-cycle multiplier (SPEC path).
module ex_mdu_ctl #(
   parameter int XLEN = 32
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   ex_mdu_ctl_if.slave mdu
);
   localparam int CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, SPEC, DONE} state_t;

   state_t            state, state_nx;
   logic              accept, finish;
   logic [2:0]        op_r;
   logic [XLEN-1:0]   a_r, b_r, b_mag;
   logic              sa, sb;
   logic [XLEN-1:0]   hi, lo, hi_nx, lo_nx;
   logic [CNT_W-1:0]  cnt;
   logic [XLEN-1:0]   data_q;

   // start-time decode
   logic [2:0]      op_in;
   logic [XLEN-1:0] rs1, rs2;
   logic            sa_en, sb_en, in_ovf, in_spec;

   assign op_in  = mdu.mdu_op_i;
   assign rs1    = mdu.rs1_rd_data_i;
   assign rs2    = mdu.rs2_rd_data_i;
   assign sa_en  = (op_in == 3'd1) || (op_in == 3'd2) || (op_in == 3'd4) || (op_in == 3'd6);
   assign sb_en  = (op_in == 3'd1) || (op_in == 3'd4) || (op_in == 3'd6);
   assign in_ovf = op_in[2] && !op_in[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);

   logic [XLEN-1:0] fast_res;
`ifdef MDU_FAST_MUL_EN
   localparam bit FAST_MUL = 1'b1;
   logic signed [2*XLEN+1:0] fast_p;
   // sign flags double as the sign-extension bit for each operand
   assign fast_p   = $signed({sa, a_r}) * $signed({sb, b_r});
   assign fast_res = (op_r == 3'd0) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
`else
   localparam bit FAST_MUL = 1'b0;
   assign fast_res = '0;
`endif

   assign in_spec = op_in[2] ? ((rs2 == '0) || in_ovf) : FAST_MUL;

   // FSM
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      finish   = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (mdu.mdu_start_i) begin
               accept   = 1'b1;
               state_nx = in_spec ? SPEC : CALC;
            end else begin
               state_nx = IDLE;
            end
         end
         CALC: if (cnt == '0) begin
            state_nx = DONE;
            finish   = 1'b1;
         end
         SPEC: begin
            state_nx = DONE;
            finish   = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
      if (mdu.mdu_flush_i) begin
         state_nx = IDLE;
         accept   = 1'b0;
         finish   = 1'b0;
      end
   end

   assign mdu.mdu_busy_o = (state == CALC) || (state == SPEC);
   assign mdu.mdu_done_o = (state == DONE);
   assign mdu.mdu_data_o = data_q;

   // One iteration: hi:lo is the product (mul) or partial remainder:quotient (div)
   logic [XLEN:0]   sum, sh;
   logic            ge;
   always_comb begin
      sum = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : '0);
      sh  = {hi, lo[XLEN-1]};
      ge  = (sh >= {1'b0, b_mag});
      if (op_r[2]) begin
         hi_nx = ge ? (sh[XLEN-1:0] - b_mag) : sh[XLEN-1:0];
         lo_nx = {lo[XLEN-2:0], ge};
      end else begin
         hi_nx = sum[XLEN:1];
         lo_nx = {sum[0], lo[XLEN-1:1]};
      end
   end

   // Final sign fix-up applied on the way into DONE
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, calc_res, spec_res;
   always_comb begin
      prod     = {hi_nx, lo_nx};
      prod     = (sa ^ sb) ? -prod : prod;
      quo      = (sa ^ sb) ? -lo_nx : lo_nx;
      rem      = sa ? -hi_nx : hi_nx;
      calc_res = op_r[2] ? (op_r[1] ? rem : quo)
                         : ((op_r[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
      if (!op_r[2])        spec_res = fast_res;
      else if (b_r == '0)  spec_res = op_r[1] ? a_r : '1;
      else                 spec_res = op_r[1] ? '0 : a_r;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         op_r   <= '0;
         a_r    <= '0;
         b_r    <= '0;
         b_mag  <= '0;
         sa     <= 1'b0;
         sb     <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         cnt    <= '0;
         data_q <= '0;
      end else begin
         if (accept) begin
            op_r  <= op_in;
            a_r   <= rs1;
            b_r   <= rs2;
            sa    <= sa_en & rs1[XLEN-1];
            sb    <= sb_en & rs2[XLEN-1];
            b_mag <= (sb_en & rs2[XLEN-1]) ? -rs2 : rs2;
            hi    <= '0;
            lo    <= (sa_en & rs1[XLEN-1]) ? -rs1 : rs1;
            cnt   <= CNT_W'(XLEN-1);
         end else if (state == CALC && !mdu.mdu_flush_i) begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            cnt <= cnt - CNT_W'(1);
         end
         if (finish) data_q <= (state == SPEC) ? spec_res : calc_res;
      end
   end
endmodule

// File: tb/tb_ex_mdu_ctl.sv
// Self-checking bench for ex_mdu_ctl: directed vector table, corner sequences, random vs. model.
module tb_ex_mdu_ctl;
   localparam int XLEN = 32;
   localparam int CALC_LAT = XLEN + 1;
`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = CALC_LAT;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ex_mdu_ctl_if #(.XLEN(XLEN)) mif ();
   ex_mdu_ctl #(.XLEN(XLEN)) dut (.clk_i(clk), .rst_n_i(rst_n), .mdu(mif));

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: plain arithmetic from the RV32M definition
   function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [65:0] pa, pb, p;
      int sa_i, sb_i;
      logic ovf;
      sa_i = a;
      sb_i = b;
      ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      pa = (op == 3'd1 || op == 3'd2) ? {{34{a[31]}}, a} : {34'b0, a};
      pb = (op == 3'd1) ? {{34{b[31]}}, b} : {34'b0, b};
      p  = pa * pb;
      case (op)
         3'd0:    return p[31:0];
         3'd1, 3'd2, 3'd3: return p[63:32];
         3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa_i / sb_i);
         3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6:    return (b == 0) ? a : ovf ? 32'd0 : 32'(sa_i % sb_i);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (!op[2]) return MUL_LAT;
      if (b == 0) return 2;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return CALC_LAT;
   endfunction

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int n);
      @(negedge clk);
      mif.mdu_op_i = op;
      mif.rs1_rd_data_i = a;
      mif.rs2_rd_data_i = b;
      mif.mdu_start_i = 1'b1;
      @(posedge clk); #1;
      mif.mdu_start_i = 1'b0;
      n = 1;
      while (!mif.mdu_done_o && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      res = mif.mdu_data_o;
   endtask

   task automatic count_done(input int cyc, output int d);
      d = 0;
      repeat (cyc) begin
         @(posedge clk); #1;
         if (mif.mdu_done_o) d++;
      end
   endtask

   initial begin
      logic [31:0] res, last_exp;
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      int n, d;

      tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
      tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT};
      tbl[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
      tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT};
      tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, CALC_LAT};
      tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, CALC_LAT};
      tbl[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        CALC_LAT};
      tbl[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         CALC_LAT};
      tbl[8]  = '{3'd4, 32'd123,        32'd0,         32'hFFFF_FFFF, 2};
      tbl[9]  = '{3'd7, 32'd5,          32'd0,         32'd5,         2};
      tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2};
      tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2};
      tbl[12] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         CALC_LAT};

      mif.mdu_start_i = 1'b0;
      mif.mdu_op_i = '0;
      mif.rs1_rd_data_i = '0;
      mif.rs2_rd_data_i = '0;
      mif.mdu_flush_i = 1'b0;

      #12;
      chk("reset_busy", 32'(mif.mdu_busy_o), 32'd0);
      chk("reset_done", 32'(mif.mdu_done_o), 32'd0);
      chk("reset_data", mif.mdu_data_o, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, n);
         chk($sformatf("vec%0d_data", i), res, tbl[i].exp);
         chk($sformatf("vec%0d_lat", i), 32'(n), 32'(tbl[i].lat));
      end

      // start while busy is ignored
      @(negedge clk);
      mif.mdu_op_i = 3'd5; mif.rs1_rd_data_i = 32'd100; mif.rs2_rd_data_i = 32'd7;
      mif.mdu_start_i = 1'b1;
      @(posedge clk); #1;
      mif.mdu_start_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("busy_mid_calc", 32'(mif.mdu_busy_o), 32'd1);
      @(negedge clk);
      mif.mdu_op_i = 3'd0; mif.rs1_rd_data_i = 32'd3; mif.rs2_rd_data_i = 32'd4;
      mif.mdu_start_i = 1'b1;
      @(posedge clk); #1;
      mif.mdu_start_i = 1'b0;
      n = 6;
      while (!mif.mdu_done_o && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("busy_ign_lat", 32'(n), 32'(CALC_LAT));
      chk("busy_ign_data", mif.mdu_data_o, 32'd14);
      last_exp = 32'd14;
      count_done(40, d);
      chk("busy_ign_no_2nd", 32'(d), 32'd0);

      // flush at cycle 10 of a divide
      @(negedge clk);
      mif.mdu_op_i = 3'd5; mif.rs1_rd_data_i = 32'd1000; mif.rs2_rd_data_i = 32'd3;
      mif.mdu_start_i = 1'b1;
      @(posedge clk); #1;
      mif.mdu_start_i = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      mif.mdu_flush_i = 1'b1;
      @(posedge clk); #1;
      mif.mdu_flush_i = 1'b0;
      chk("flush_busy", 32'(mif.mdu_busy_o), 32'd0);
      chk("flush_data", mif.mdu_data_o, last_exp);
      count_done(40, d);
      chk("flush_no_done", 32'(d), 32'd0);

      // flush and start together: start dropped
      @(negedge clk);
      mif.mdu_start_i = 1'b1;
      mif.mdu_flush_i = 1'b1;
      @(posedge clk); #1;
      mif.mdu_start_i = 1'b0;
      mif.mdu_flush_i = 1'b0;
      chk("flush_start_busy", 32'(mif.mdu_busy_o), 32'd0);
      count_done(40, d);
      chk("flush_start_no_done", 32'(d), 32'd0);
      chk("flush_start_data", mif.mdu_data_o, last_exp);

      // back-to-back: second start lands in the DONE cycle
      run_op(3'd5, 32'd100, 32'd7, res, n);
      chk("b2b_first", res, 32'd14);
      run_op(3'd7, 32'd100, 32'd7, res, n);
      chk("b2b_second", res, 32'd2);
      chk("b2b_lat", 32'(n), 32'(CALC_LAT));

      // async reset mid-CALC
      @(negedge clk);
      mif.mdu_op_i = 3'd4; mif.rs1_rd_data_i = 32'd77; mif.rs2_rd_data_i = 32'd5;
      mif.mdu_start_i = 1'b1;
      @(posedge clk); #1;
      mif.mdu_start_i = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", 32'(mif.mdu_busy_o), 32'd0);
      chk("rst_mid_done", 32'(mif.mdu_done_o), 32'd0);
      chk("rst_mid_data", mif.mdu_data_o, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // randomized against the reference model
      for (int k = 0; k < 150; k++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 20));
            2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            3: ra = 32'($urandom_range(0, 1000));
            default: ;
         endcase
         run_op(rop, ra, rb, res, n);
         chk($sformatf("rnd%0d_op%0d_%h_%h", k, rop, ra, rb), res, ref_mdu(rop, ra, rb));
         chk($sformatf("rnd%0d_lat", k), 32'(n), 32'(ref_lat(rop, ra, rb)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
